// File: rtl/preg_busy_table.sv
// Physical-register busy table: tracks which renamed destinations still await writeback
// and answers per-source ready queries for the current dual-issue rename group.
module preg_busy_table #(
  parameter int PREG_NUM = 64,
  parameter int PREG_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              map_done,
  input  logic              inst1_rf_we,
  input  logic [PREG_W-1:0] inst1_phy_dest,
  input  logic              inst2_rf_we,
  input  logic [PREG_W-1:0] inst2_phy_dest,
  input  logic [PREG_W-1:0] inst1_phy_src1,
  input  logic [PREG_W-1:0] inst1_phy_src2,
  input  logic [PREG_W-1:0] inst2_phy_src1,
  input  logic [PREG_W-1:0] inst2_phy_src2,
  output logic              inst1_src1_ready,
  output logic              inst1_src2_ready,
  output logic              inst2_src1_ready,
  output logic              inst2_src2_ready,
  input  logic              wb0_valid,
  input  logic [PREG_W-1:0] wb0_phy_dest,
  input  logic              wb1_valid,
  input  logic [PREG_W-1:0] wb1_phy_dest,
  input  logic              wb2_valid,
  input  logic [PREG_W-1:0] wb2_phy_dest,
  output logic [PREG_W:0]   busy_count
);

  localparam int CW = PREG_W + 1;

  logic [PREG_NUM-1:0] busy;
  logic [PREG_NUM-1:0] clear_vec;
  logic [PREG_NUM-1:0] set_vec;
  logic [PREG_NUM-1:0] busy_next;
  logic [CW-1:0]       added;
  logic [CW-1:0]       removed;
  logic                fwd_src1;
  logic                fwd_src2;

  function automatic logic lookup(input logic [PREG_W-1:0] s,
                                  input logic [PREG_NUM-1:0] bv,
                                  input logic [PREG_NUM-1:0] wb_hit);
    return (s == '0) || !bv[s] || wb_hit[s];
  endfunction

  always_comb begin
    clear_vec = '0;
    set_vec   = '0;
    if (wb0_valid) clear_vec[wb0_phy_dest] = 1'b1;
    if (wb1_valid) clear_vec[wb1_phy_dest] = 1'b1;
    if (wb2_valid) clear_vec[wb2_phy_dest] = 1'b1;
    if (map_done && inst1_rf_we && inst1_phy_dest != '0) set_vec[inst1_phy_dest] = 1'b1;
    if (map_done && inst2_rf_we && inst2_phy_dest != '0) set_vec[inst2_phy_dest] = 1'b1;
    busy_next    = (busy & ~clear_vec) | set_vec;
    busy_next[0] = 1'b0;
    // Counter deltas only count real transitions so it tracks popcount(busy) exactly.
    added   = CW'($countones(set_vec & ~busy));
    removed = CW'($countones(busy & clear_vec & ~set_vec));
  end

  always_comb begin
    fwd_src1 = inst1_rf_we && (inst1_phy_dest != '0) && (inst2_phy_src1 == inst1_phy_dest);
    fwd_src2 = inst1_rf_we && (inst1_phy_dest != '0) && (inst2_phy_src2 == inst1_phy_dest);
    inst1_src1_ready = lookup(inst1_phy_src1, busy, clear_vec);
    inst1_src2_ready = lookup(inst1_phy_src2, busy, clear_vec);
    // Slot-1 producer in the same group has not executed, so it overrides the wb bypass.
    inst2_src1_ready = lookup(inst2_phy_src1, busy, clear_vec) && !fwd_src1;
    inst2_src2_ready = lookup(inst2_phy_src2, busy, clear_vec) && !fwd_src2;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= busy_count + added - removed;
    end
  end

endmodule

// File: tb/tb_preg_busy_table.sv
// Self-checking bench for preg_busy_table: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an array-based busy model.
module tb_preg_busy_table;
  localparam int PREG_NUM = 64;
  localparam int PREG_W   = 6;

  logic clk = 1'b0;
  logic reset, flush, map_done;
  logic inst1_rf_we, inst2_rf_we;
  logic [PREG_W-1:0] inst1_phy_dest, inst2_phy_dest;
  logic [PREG_W-1:0] inst1_phy_src1, inst1_phy_src2, inst2_phy_src1, inst2_phy_src2;
  logic inst1_src1_ready, inst1_src2_ready, inst2_src1_ready, inst2_src2_ready;
  logic wb0_valid, wb1_valid, wb2_valid;
  logic [PREG_W-1:0] wb0_phy_dest, wb1_phy_dest, wb2_phy_dest;
  logic [PREG_W:0] busy_count;

  int vectors = 0;
  int miscompares = 0;
  bit model_busy[PREG_NUM];
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  preg_busy_table #(.PREG_NUM(PREG_NUM), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .map_done(map_done),
    .inst1_rf_we(inst1_rf_we), .inst1_phy_dest(inst1_phy_dest),
    .inst2_rf_we(inst2_rf_we), .inst2_phy_dest(inst2_phy_dest),
    .inst1_phy_src1(inst1_phy_src1), .inst1_phy_src2(inst1_phy_src2),
    .inst2_phy_src1(inst2_phy_src1), .inst2_phy_src2(inst2_phy_src2),
    .inst1_src1_ready(inst1_src1_ready), .inst1_src2_ready(inst1_src2_ready),
    .inst2_src1_ready(inst2_src1_ready), .inst2_src2_ready(inst2_src2_ready),
    .wb0_valid(wb0_valid), .wb0_phy_dest(wb0_phy_dest),
    .wb1_valid(wb1_valid), .wb1_phy_dest(wb1_phy_dest),
    .wb2_valid(wb2_valid), .wb2_phy_dest(wb2_phy_dest),
    .busy_count(busy_count)
  );

  function automatic bit model_ready(input logic [PREG_W-1:0] s, input bit slot2);
    bit r;
    r = (s == 0) || !model_busy[s]
        || (wb0_valid && wb0_phy_dest == s)
        || (wb1_valid && wb1_phy_dest == s)
        || (wb2_valid && wb2_phy_dest == s);
    if (slot2 && inst1_rf_we && inst1_phy_dest != 0 && s == inst1_phy_dest) r = 1'b0;
    return r;
  endfunction

  function automatic int model_count();
    int c = 0;
    foreach (model_busy[i]) c += int'(model_busy[i]);
    return c;
  endfunction

  // Reference update: clears first, then allocations, so a same-index set survives.
  always @(posedge clk) begin
    if (reset || flush) begin
      foreach (model_busy[i]) model_busy[i] = 1'b0;
    end else begin
      if (wb0_valid) model_busy[wb0_phy_dest] = 1'b0;
      if (wb1_valid) model_busy[wb1_phy_dest] = 1'b0;
      if (wb2_valid) model_busy[wb2_phy_dest] = 1'b0;
      if (map_done && inst1_rf_we && inst1_phy_dest != 0) model_busy[inst1_phy_dest] = 1'b1;
      if (map_done && inst2_rf_we && inst2_phy_dest != 0) model_busy[inst2_phy_dest] = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("model_i1s1", 32'(inst1_src1_ready), 32'(model_ready(inst1_phy_src1, 1'b0)));
      checkOutput("model_i1s2", 32'(inst1_src2_ready), 32'(model_ready(inst1_phy_src2, 1'b0)));
      checkOutput("model_i2s1", 32'(inst2_src1_ready), 32'(model_ready(inst2_phy_src1, 1'b1)));
      checkOutput("model_i2s2", 32'(inst2_src2_ready), 32'(model_ready(inst2_phy_src2, 1'b1)));
      checkOutput("model_count", 32'(busy_count), 32'(model_count()));
    end
  end

  // Advance to just after the next rising edge and return all inputs to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    reset = 0; flush = 0; map_done = 0;
    inst1_rf_we = 0; inst1_phy_dest = 0; inst2_rf_we = 0; inst2_phy_dest = 0;
    inst1_phy_src1 = 0; inst1_phy_src2 = 0; inst2_phy_src1 = 0; inst2_phy_src2 = 0;
    wb0_valid = 0; wb0_phy_dest = 0; wb1_valid = 0; wb1_phy_dest = 0;
    wb2_valid = 0; wb2_phy_dest = 0;
  endtask

  function automatic logic [PREG_W-1:0] rand_tag();
    if ($urandom_range(0, 9) < 8) return PREG_W'($urandom_range(0, 15));
    return PREG_W'($urandom_range(0, PREG_NUM - 1));
  endfunction

  initial begin
    reset = 1; flush = 0; map_done = 0;
    inst1_rf_we = 0; inst1_phy_dest = 0; inst2_rf_we = 0; inst2_phy_dest = 0;
    inst1_phy_src1 = 0; inst1_phy_src2 = 0; inst2_phy_src1 = 0; inst2_phy_src2 = 0;
    wb0_valid = 0; wb0_phy_dest = 0; wb1_valid = 0; wb1_phy_dest = 0;
    wb2_valid = 0; wb2_phy_dest = 0;

    applyStimulus(); reset = 1;
    applyStimulus();
    model_on = 1'b1;
    inst1_phy_src1 = 0; inst1_phy_src2 = 5; inst2_phy_src1 = 63;
    @(negedge clk);
    checkOutput("rst_src0", 32'(inst1_src1_ready), 1);
    checkOutput("rst_src5", 32'(inst1_src2_ready), 1);
    checkOutput("rst_src63", 32'(inst2_src1_ready), 1);
    checkOutput("rst_count", 32'(busy_count), 0);

    applyStimulus();
    map_done = 1; inst1_rf_we = 1; inst1_phy_dest = 7; inst2_rf_we = 1; inst2_phy_dest = 9;
    applyStimulus();
    inst1_phy_src1 = 7; inst1_phy_src2 = 9;
    @(negedge clk);
    checkOutput("alloc_src7", 32'(inst1_src1_ready), 0);
    checkOutput("alloc_src9", 32'(inst1_src2_ready), 0);
    checkOutput("alloc_count", 32'(busy_count), 2);
    applyStimulus();
    inst1_phy_src1 = 7; wb0_valid = 1; wb0_phy_dest = 7;
    @(negedge clk);
    checkOutput("bypass_src7", 32'(inst1_src1_ready), 1);
    applyStimulus();
    inst1_phy_src1 = 7; inst1_phy_src2 = 9;
    @(negedge clk);
    checkOutput("wb_src7", 32'(inst1_src1_ready), 1);
    checkOutput("still_src9", 32'(inst1_src2_ready), 0);
    checkOutput("wb_count", 32'(busy_count), 1);

    applyStimulus();
    map_done = 1; inst1_rf_we = 1; inst1_phy_dest = 12; inst2_phy_src1 = 12;
    inst1_phy_src1 = 12; wb1_valid = 1; wb1_phy_dest = 12;
    @(negedge clk);
    checkOutput("fwd_i2s1", 32'(inst2_src1_ready), 0);
    checkOutput("bypass_i1s1", 32'(inst1_src1_ready), 1);
    applyStimulus();
    inst1_phy_src1 = 12;
    @(negedge clk);
    checkOutput("setwins_src12", 32'(inst1_src1_ready), 0);
    checkOutput("setwins_count", 32'(busy_count), 2);

    applyStimulus();
    map_done = 1; inst1_rf_we = 1; inst1_phy_dest = 0;
    applyStimulus();
    @(negedge clk);
    checkOutput("zero_src0", 32'(inst1_src1_ready), 1);
    checkOutput("zero_count", 32'(busy_count), 2);

    applyStimulus();
    map_done = 1; inst1_rf_we = 1; inst1_phy_dest = 20; inst2_rf_we = 1; inst2_phy_dest = 21;
    applyStimulus();
    map_done = 1; inst1_rf_we = 1; inst1_phy_dest = 22;
    applyStimulus();
    flush = 1; map_done = 1; inst1_rf_we = 1; inst1_phy_dest = 23; wb0_valid = 1; wb0_phy_dest = 9;
    @(negedge clk);
    checkOutput("preflush_count", 32'(busy_count), 5);
    applyStimulus();
    inst1_phy_src1 = 20; inst1_phy_src2 = 21; inst2_phy_src1 = 22; inst2_phy_src2 = 23;
    @(negedge clk);
    checkOutput("flush_src20", 32'(inst1_src1_ready), 1);
    checkOutput("flush_src21", 32'(inst1_src2_ready), 1);
    checkOutput("flush_src22", 32'(inst2_src1_ready), 1);
    checkOutput("flush_src23", 32'(inst2_src2_ready), 1);
    checkOutput("flush_count", 32'(busy_count), 0);

    applyStimulus();
    map_done = 1; inst1_rf_we = 1; inst1_phy_dest = 30; inst2_rf_we = 1; inst2_phy_dest = 31;
    applyStimulus();
    wb0_valid = 1; wb0_phy_dest = 30; wb2_valid = 1; wb2_phy_dest = 30;
    @(negedge clk);
    checkOutput("dupwb_before", 32'(busy_count), 2);
    applyStimulus();
    inst1_phy_src1 = 30; inst1_phy_src2 = 31;
    @(negedge clk);
    checkOutput("dupwb_count", 32'(busy_count), 1);
    checkOutput("dupwb_src30", 32'(inst1_src1_ready), 1);
    checkOutput("dupwb_src31", 32'(inst1_src2_ready), 0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      applyStimulus();
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 79) == 0);
      map_done = ($urandom_range(0, 9) < 6);
      inst1_rf_we = $urandom_range(0, 1);
      inst2_rf_we = $urandom_range(0, 1);
      inst1_phy_dest = rand_tag(); inst2_phy_dest = rand_tag();
      inst1_phy_src1 = ($urandom_range(0, 3) == 0) ? inst1_phy_dest : rand_tag();
      inst1_phy_src2 = rand_tag();
      inst2_phy_src1 = ($urandom_range(0, 3) == 0) ? inst1_phy_dest : rand_tag();
      inst2_phy_src2 = rand_tag();
      wb0_valid = ($urandom_range(0, 9) < 4); wb0_phy_dest = rand_tag();
      wb1_valid = ($urandom_range(0, 9) < 4); wb1_phy_dest = rand_tag();
      wb2_valid = ($urandom_range(0, 9) < 3);
      wb2_phy_dest = ($urandom_range(0, 3) == 0) ? wb0_phy_dest : rand_tag();
    end
    applyStimulus();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
